// File: rtl/lcd_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_tester_pkg
// Description : Shared constants, pattern encodings and press-FSM states for
//               the LCD tester control path.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_tester_pkg;

    localparam int unsigned c_idx_w       = 4;
    localparam int unsigned c_pattern_num = 9;

    // Pattern index encodings seen by the colour/grayscale mux
    localparam logic [c_idx_w-1:0] c_pat_red       = 4'd0;
    localparam logic [c_idx_w-1:0] c_pat_green     = 4'd1;
    localparam logic [c_idx_w-1:0] c_pat_blue      = 4'd2;
    localparam logic [c_idx_w-1:0] c_pat_black     = 4'd3;
    localparam logic [c_idx_w-1:0] c_pat_white     = 4'd4;
    localparam logic [c_idx_w-1:0] c_pat_ramp_r    = 4'd5;
    localparam logic [c_idx_w-1:0] c_pat_ramp_g    = 4'd6;
    localparam logic [c_idx_w-1:0] c_pat_ramp_b    = 4'd7;
    localparam logic [c_idx_w-1:0] c_pat_gray_bars = 4'd8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_press = 2'd1;
    localparam logic [1:0] c_st_held  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        PRESS = c_st_press,
        HELD  = c_st_held
    } press_state_t;

    function automatic logic [c_idx_w-1:0] next_pattern(
        input logic [c_idx_w-1:0] idx,
        input int unsigned        num
    );
        return (32'(idx) == num - 32'd1) ? '0 : idx + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_pattern_sel_if.sv
`default_nettype none
// ============================================================================
// Module      : key_pattern_sel_if
// Description : Button/auto-advance inputs and pattern-select outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_pattern_sel_if;
    import lcd_tester_pkg::*;

    logic               key_in;
    logic               auto_en;
    logic [c_idx_w-1:0] pattern_idx;
    logic               step_pulse;
    logic               long_pulse;
    logic               key_pressed;

    modport master (
        output key_in,
        output auto_en,
        input  pattern_idx,
        input  step_pulse,
        input  long_pulse,
        input  key_pressed
    );

    modport slave (
        input  key_in,
        input  auto_en,
        output pattern_idx,
        output step_pulse,
        output long_pulse,
        output key_pressed
    );

endinterface
`default_nettype wire

// File: rtl/key_pattern_sel_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser and stable-level debounce for an
//               active-low push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter logic [31:0] DEBOUNCE_CYC = 32'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_pressed
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic [31:0] r_cnt;

    // Released level is 1, so the chain powers up as "not pressed"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == DEBOUNCE_CYC - 32'd1) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end

    assign key_pressed = ~r_level;

endmodule
`default_nettype wire

// File: rtl/key_pattern_sel.sv
`default_nettype none
// ============================================================================
// Module      : key_pattern_sel
// Description : Short/long press classification, pattern index stepping and
//               timed auto-advance for the LCD tester pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
module key_pattern_sel
    import lcd_tester_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYC = 32'd500000,
    parameter logic [31:0] LONG_CYC     = 32'd50000000,
    parameter logic [31:0] AUTO_CYC     = 32'd100000000,
    parameter int unsigned PATTERN_NUM  = c_pattern_num
) (
    input  logic             clk,
    input  logic             rst_n,
    key_pattern_sel_if.slave bus
);

    if (PATTERN_NUM > 16 || PATTERN_NUM < 1) begin : g_bad_pattern_num
        $error("key_pattern_sel: PATTERN_NUM must lie in 1..16");
    end

    if (DEBOUNCE_CYC == 32'd0 || LONG_CYC == 32'd0 || AUTO_CYC == 32'd0) begin : g_bad_cycles
        $error("key_pattern_sel: cycle counts must be non-zero");
    end

    press_state_t       r_state;
    press_state_t       w_state_nxt;
    logic [31:0]        r_hold;
    logic [31:0]        r_auto_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic               w_key_pressed;
    logic               w_short_step;
    logic               w_long;
    logic               w_auto_run;
    logic               w_auto_step;
    logic               w_step;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (bus.key_in),
        .key_pressed (w_key_pressed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Long detection wins over a release landing on the same cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_short_step = 1'b0;
        w_long       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_key_pressed) begin
                    w_state_nxt = PRESS;
                end
            end
            PRESS: begin
                if (r_hold == LONG_CYC - 32'd1) begin
                    w_long      = 1'b1;
                    w_state_nxt = HELD;
                end else if (!w_key_pressed) begin
                    w_short_step = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            HELD: begin
                if (!w_key_pressed) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state != PRESS) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 32'd1;
        end
    end

    // Only counting in IDLE keeps auto and short-press steps mutually exclusive
    assign w_auto_run  = bus.auto_en && (r_state == IDLE);
    assign w_auto_step = w_auto_run && (r_auto_cnt == AUTO_CYC - 32'd1);
    assign w_step      = w_short_step || w_auto_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (!w_auto_run || w_auto_step) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_long) begin
            r_idx <= '0;
        end else if (w_step) begin
            r_idx <= next_pattern(r_idx, PATTERN_NUM);
        end
    end

    assign bus.pattern_idx = r_idx;
    assign bus.step_pulse  = w_step;
    assign bus.long_pulse  = w_long;
    assign bus.key_pressed = w_key_pressed;

endmodule
`default_nettype wire

// File: tb/tb_key_pattern_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_pattern_sel
// Description : Directed and randomized bench for key_pattern_sel against a
//               cycle-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_pattern_sel;
    import lcd_tester_pkg::*;

    localparam int c_deb  = 4;
    localparam int c_long = 20;
    localparam int c_auto = 30;
    localparam int c_pn   = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_pattern_sel_if bus();

    key_pattern_sel #(
        .DEBOUNCE_CYC (32'(c_deb)),
        .LONG_CYC     (32'(c_long)),
        .AUTO_CYC     (32'(c_auto)),
        .PATTERN_NUM  (c_pn)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_step = 0;
    int n_long = 0;

    // Reference model: key level is accepted once the synchronised input
    // (key_in two cycles back) has disagreed with it for c_deb cycles running.
    bit kh[$];
    bit m_acc;
    int m_prun;
    bit m_prev_pr;
    int m_arun;
    int m_idx;
    bit e_pressed, e_step, e_long;

    always @(negedge clk) begin
        if (!rst_n) begin
            kh = {};
            repeat (8) kh.push_back(1'b1);
            m_acc = 1'b1; m_prun = 0; m_prev_pr = 1'b0; m_arun = 0; m_idx = 0;
            e_pressed = 1'b0; e_step = 1'b0; e_long = 1'b0;
        end else begin
            bit differ;
            bit short_rel;
            bit auto_due;
            kh.push_back(bus.key_in);
            kh.pop_front();
            differ = 1'b1;
            for (int j = 3; j < 3 + c_deb; j++)
                if (kh[7 - j] == m_acc) differ = 1'b0;
            if (differ) m_acc = !m_acc;
            e_pressed = !m_acc;
            e_long    = (m_prun == c_long);
            short_rel = !e_pressed && (m_prun >= 1) && (m_prun < c_long);
            m_arun    = (bus.auto_en && !m_prev_pr) ? m_arun + 1 : 0;
            auto_due  = (m_arun > 0) && (m_arun % c_auto == 0);
            e_step    = short_rel || auto_due;
        end
        checks++;
        if (bus.pattern_idx !== 4'(m_idx)) begin
            errors++;
            $display("FAIL model pattern_idx @%0t: got %0d expected %0d", $time, bus.pattern_idx, m_idx);
        end
        checks++;
        if (bus.step_pulse !== e_step) begin
            errors++;
            $display("FAIL model step_pulse @%0t: got %0b expected %0b", $time, bus.step_pulse, e_step);
        end
        checks++;
        if (bus.long_pulse !== e_long) begin
            errors++;
            $display("FAIL model long_pulse @%0t: got %0b expected %0b", $time, bus.long_pulse, e_long);
        end
        checks++;
        if (bus.key_pressed !== e_pressed) begin
            errors++;
            $display("FAIL model key_pressed @%0t: got %0b expected %0b", $time, bus.key_pressed, e_pressed);
        end
        if (rst_n) begin
            if (e_long)      m_idx = 0;
            else if (e_step) m_idx = (m_idx + 1) % c_pn;
            m_prun    = e_pressed ? m_prun + 1 : 0;
            m_prev_pr = e_pressed;
            if (bus.step_pulse) n_step++;
            if (bus.long_pulse) n_long++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.key_in = 1'b1; bus.auto_en = 1'b0; rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press(input int lo, input int hi);
        bus.key_in = 1'b0;
        tick(lo);
        bus.key_in = 1'b1;
        tick(hi);
    endtask

    task automatic test_reset();
        int s0, l0;
        bus.key_in = 1'b1; bus.auto_en = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.pattern_idx !== 4'd0 || bus.step_pulse !== 1'b0 || bus.long_pulse !== 1'b0 || bus.key_pressed !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got idx=%0d step=%0b long=%0b pressed=%0b expected all 0",
                     bus.pattern_idx, bus.step_pulse, bus.long_pulse, bus.key_pressed);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_step; l0 = n_long;
        tick(100);
        checks++;
        if (n_step - s0 !== 0) begin errors++; $display("FAIL idle_steps: got %0d expected 0", n_step - s0); end
        checks++;
        if (n_long - l0 !== 0) begin errors++; $display("FAIL idle_longs: got %0d expected 0", n_long - l0); end
        checks++;
        if (bus.pattern_idx !== 4'd0) begin errors++; $display("FAIL idle_idx: got %0d expected 0", bus.pattern_idx); end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        bus.key_in = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) bus.key_in = 1'b1;
            @(negedge clk);
            if (bus.key_pressed) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch_pressed: got 1 expected 0"); end
        checks++;
        if (bus.pattern_idx !== 4'd0) begin errors++; $display("FAIL glitch_idx: got %0d expected 0", bus.pattern_idx); end
    endtask

    task automatic test_short_press();
        int first = -1;
        int cnt   = 0;
        bus.key_in = 1'b0;
        tick(10);
        bus.key_in = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (bus.key_pressed !== 1'b1) begin errors++; $display("FAIL short_held: got %0b expected 1", bus.key_pressed); end
            end
            if (bus.step_pulse) begin
                cnt++;
                if (first < 0) first = k;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first !== c_deb + 2) begin errors++; $display("FAIL short_latency: got %0d expected %0d", first, c_deb + 2); end
        checks++;
        if (cnt !== 1) begin errors++; $display("FAIL short_count: got %0d expected 1", cnt); end
        checks++;
        if (bus.pattern_idx !== 4'd1) begin errors++; $display("FAIL short_idx: got %0d expected 1", bus.pattern_idx); end
    endtask

    task automatic test_wrap();
        int s0;
        do_reset();
        s0 = n_step;
        for (int p = 0; p < c_pn; p++) begin
            press(8, 12);
            checks++;
            if (bus.pattern_idx !== 4'((p + 1) % c_pn)) begin
                errors++;
                $display("FAIL wrap_idx[%0d]: got %0d expected %0d", p, bus.pattern_idx, (p + 1) % c_pn);
            end
        end
        checks++;
        if (n_step - s0 !== c_pn) begin errors++; $display("FAIL wrap_steps: got %0d expected %0d", n_step - s0, c_pn); end
    endtask

    task automatic test_long_press();
        int s0, l0;
        do_reset();
        repeat (5) press(8, 12);
        checks++;
        if (bus.pattern_idx !== 4'd5) begin errors++; $display("FAIL long_pre_idx: got %0d expected 5", bus.pattern_idx); end
        s0 = n_step; l0 = n_long;
        press(30, 15);
        checks++;
        if (n_long - l0 !== 1) begin errors++; $display("FAIL long_count: got %0d expected 1", n_long - l0); end
        checks++;
        if (n_step - s0 !== 0) begin errors++; $display("FAIL long_steps: got %0d expected 0", n_step - s0); end
        checks++;
        if (bus.pattern_idx !== 4'd0) begin errors++; $display("FAIL long_idx: got %0d expected 0", bus.pattern_idx); end
    endtask

    task automatic test_auto();
        int t[$];
        do_reset();
        bus.auto_en = 1'b1;
        for (int k = 0; k < 95; k++) begin
            @(negedge clk);
            if (bus.step_pulse) t.push_back(k);
            @(posedge clk); #1;
        end
        bus.auto_en = 1'b0;
        checks++;
        if (t.size() !== 3) begin
            errors++; $display("FAIL auto_count: got %0d expected 3", t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (t[i] !== (i + 1) * c_auto - 1) begin
                    errors++; $display("FAIL auto_time[%0d]: got %0d expected %0d", i, t[i], (i + 1) * c_auto - 1);
                end
            end
        end
        checks++;
        if (bus.pattern_idx !== 4'd3) begin errors++; $display("FAIL auto_idx: got %0d expected 3", bus.pattern_idx); end
    endtask

    task automatic test_auto_restart();
        int t[$];
        int rel;
        do_reset();
        rel = 19 + 8;
        for (int k = 0; k < 81; k++) begin
            if (k == 0)   bus.auto_en = 1'b1;
            if (k == 19)  bus.key_in  = 1'b0;
            if (k == rel) bus.key_in  = 1'b1;
            @(negedge clk);
            if (bus.step_pulse) t.push_back(k);
            @(posedge clk); #1;
        end
        bus.auto_en = 1'b0;
        checks++;
        if (t.size() !== 2) begin
            errors++; $display("FAIL restart_count: got %0d expected 2", t.size());
        end else begin
            checks++;
            if (t[0] !== rel + c_deb + 2) begin errors++; $display("FAIL restart_short: got %0d expected %0d", t[0], rel + c_deb + 2); end
            checks++;
            if (t[1] !== rel + c_deb + 2 + c_auto) begin errors++; $display("FAIL restart_auto: got %0d expected %0d", t[1], rel + c_deb + 2 + c_auto); end
        end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        press(8, 12);
        bus.key_in = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.key_pressed !== 1'b0 || bus.pattern_idx !== 4'd0) begin
            errors++;
            $display("FAIL midreset_state: got pressed=%0b idx=%0d expected 0/0", bus.key_pressed, bus.pattern_idx);
        end
        tick(2);
        rst_n = 1'b1;
        tick(10);
        checks++;
        if (bus.key_pressed !== 1'b1) begin errors++; $display("FAIL midreset_repress: got %0b expected 1", bus.key_pressed); end
        bus.key_in = 1'b1;
        tick(12);
        checks++;
        if (bus.pattern_idx !== 4'd1) begin errors++; $display("FAIL midreset_idx: got %0d expected 1", bus.pattern_idx); end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 60; s++) begin
            bus.key_in  = ~bus.key_in;
            bus.auto_en = ($urandom_range(0, 2) == 0);
            tick($urandom_range(1, 35));
        end
        bus.key_in = 1'b1; bus.auto_en = 1'b0;
        tick(40);
    endtask

    initial begin
        bus.key_in  = 1'b1;
        bus.auto_en = 1'b0;
        test_reset();
        test_glitch();
        test_short_press();
        test_wrap();
        test_long_press();
        test_auto();
        test_auto_restart();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
